// File: rtl/mdc_if.sv
// mdc_if: operand/result valid-ready bundle between a GCD requester and mdc_core.
interface mdc_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] gcd_o;
  logic [CNT_W-1:0] cycles_o;
  logic             zero_o;
  logic             busy_o;
  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, gcd_o, cycles_o, zero_o, busy_o
  );
  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, gcd_o, cycles_o, zero_o, busy_o
  );
endinterface

// File: rtl/mdc_core.sv
// mdc_core: iterative GCD engine, subtractive (MODE=0) or binary Stein (MODE=1),
// one operation in flight, valid/ready on both sides.
module mdc_core #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input logic  clk,
  input logic  rstn_i,
  mdc_if.slave s
);
  localparam int KW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_x, r_y, r_gcd;
  logic [KW-1:0]    r_k;
  logic [CNT_W-1:0] r_cnt, r_cycles;
  logic             r_zero;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_bin, w_xe, w_ye;
  assign w_cnt_inc     = &r_cnt ? r_cnt : r_cnt + 1'b1;
  assign w_bin         = MODE == 1;
  assign w_xe          = ~r_x[0];
  assign w_ye          = ~r_y[0];
  assign s.in_ready_o  = r_state == IDLE;
  assign s.out_valid_o = r_state == DONE;
  assign s.busy_o      = r_state != IDLE;
  assign s.gcd_o       = r_gcd;
  assign s.cycles_o    = r_cycles;
  assign s.zero_o      = r_zero;
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_gcd    <= '0;
      r_cycles <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (s.in_valid_i) begin
          r_x   <= s.a_i;
          r_y   <= s.b_i;
          r_k   <= '0;
          r_cnt <= '0;
          if (s.a_i == '0 || s.b_i == '0) begin
            r_gcd    <= s.a_i | s.b_i;
            r_zero   <= 1'b1;
            r_cycles <= '0;
            r_state  <= DONE;
          end else begin
            r_zero  <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_cnt <= w_cnt_inc;
          // the terminating equality cycle is counted too
          if (r_x == r_y) begin
            r_gcd    <= w_bin ? r_x << r_k : r_x;
            r_cycles <= w_cnt_inc;
            r_state  <= DONE;
          end else if (w_bin && w_xe && w_ye) begin
            r_x <= r_x >> 1;
            r_y <= r_y >> 1;
            r_k <= r_k + 1'b1;
          end else if (w_bin && w_xe) r_x <= r_x >> 1;
          else if (w_bin && w_ye) r_y <= r_y >> 1;
          else if (r_x > r_y) r_x <= r_x - r_y;
          else r_y <= r_y - r_x;
        end
        DONE: if (s.out_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mdc_core.md
Name: mdc_core

Overview:
- Parametrised GCD (MDC) engine with controller and datapath in one block.
- Accepts one operand pair through a valid/ready input handshake and iterates.
- Returns the GCD, an iteration count and a zero-operand flag through a valid/ready output handshake.
- MODE selects the subtractive algorithm or the binary (Stein) algorithm; only one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- MODE, 0, algorithm select: 0 = subtractive, 1 = binary (Stein).
- CNT_W, 8, width of the cycle counter output (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands.
- a_i  in  WIDTH  operand A, unsigned.
- b_i  in  WIDTH  operand B, unsigned.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- gcd_o  out  WIDTH  GCD result.
- cycles_o  out  CNT_W  number of CALC cycles used, saturating.
- zero_o  out  1  at least one operand was zero.
- busy_o  out  1  high in CALC and DONE.

Behaviour:
- Reset: clk is the clock; rstn_i is an asynchronous, active-low reset.
  - While rstn_i is low: state = IDLE.
  - All internal registers clear.
  - Output values during reset: in_ready_o=1, out_valid_o=0, gcd_o=0, cycles_o=0, zero_o=0, busy_o=0.
  - Reset asserted mid-operation aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1, busy_o=0, out_valid_o=0.
  - Accept on a rising edge with in_valid_i && in_ready_o: x<=a_i, y<=b_i, shift k<=0, counter<=0.
  - If a_i==0 or b_i==0: go directly to DONE with gcd_o = a_i|b_i (so 0 when both are zero), zero_o=1, cycles_o=0.
  - Otherwise: go to CALC with zero_o=0.
- CALC, MODE=0; one step per cycle, counter increments every CALC cycle:
  - x==y: gcd_o<=x, go to DONE.
  - x>y: x<=x-y.
  - otherwise: y<=y-x.
- CALC, MODE=1; priority order, counter increments every CALC cycle:
  - x==y: gcd_o<=x<<k, go to DONE.
  - x and y both even: x>>=1, y>>=1, k<=k+1.
  - x even: x>>=1.
  - y even: y>>=1.
  - x>y: x<=x-y.
  - otherwise: y<=y-x.
  - k is clog2(WIDTH+1) bits wide; x<<k never exceeds WIDTH bits.
- Counter: saturates at 2^CNT_W-1 (no wrap). cycles_o is loaded from it on entry to DONE.
- Latency: out_valid_o rises after the Nth rising edge following the accepting edge, where N = cycles_o. The zero-operand case has N=0, i.e. out_valid_o is high right after the accepting edge.
- DONE:
  - out_valid_o=1, busy_o=1, in_ready_o=0.
  - gcd_o, cycles_o and zero_o are held stable until a rising edge with out_ready_i=1; then return to IDLE.
  - The next operand pair can be accepted no earlier than the following edge.
  - in_valid_i is ignored outside IDLE.
- Persistence: gcd_o, cycles_o and zero_o keep their last values in IDLE until the next result is loaded.
- Simultaneous events:
  - out_ready_i high in the same cycle DONE is entered has no effect until the next edge; DONE always lasts at least one cycle.
  - in_valid_i held high continuously is accepted once per IDLE visit.
- Arithmetic: unsigned only; subtraction is always larger minus smaller, so no underflow.

Test Plan:
- MODE=0, WIDTH=8: a=12, b=8, out_ready_i=1 -> gcd_o=4, cycles_o=3, zero_o=0; out_valid_o high for exactly 1 cycle, 3 edges after accept.
- MODE=1, WIDTH=8: a=12, b=8 -> gcd_o=4, cycles_o=6; a=48, b=18 -> gcd_o=6.
- MODE=0, WIDTH=8, CNT_W=4: a=255, b=1 -> gcd_o=1, cycles_o=15 (saturated); with CNT_W=8 -> cycles_o=255.
- Zero operands: a=0, b=9 -> gcd_o=9, zero_o=1, cycles_o=0; a=0, b=0 -> gcd_o=0, zero_o=1; out_valid_o is high the cycle after accept.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE with in_valid_i=1 -> outputs stable, in_ready_o=0, no new accept; release out_ready_i -> IDLE, then the next pair is accepted.
- Reset mid-CALC: assert rstn_i=0 during a=200, b=3 -> immediately IDLE, in_ready_o=1, out_valid_o=0, gcd_o=0; a new pair (a=10, b=4) completes with gcd_o=2.
